// File: rtl/ahb_req_arbiter.sv
// Round-robin arbiter that turns NREQ simple client requests into single
// non-pipelined AHB3-Lite transfers and routes the response back to the winner.
module ahb_req_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*3-1:0]        req_size,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          rsp_valid,
    output logic                     rsp_err,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     busy,
    output logic                     HSEL,
    output logic [ADDR_W-1:0]        HADDR,
    output logic [1:0]               HTRANS,
    output logic                     HWRITE,
    output logic [2:0]               HSIZE,
    output logic [2:0]               HBURST,
    output logic [3:0]               HPROT,
    output logic [DATA_W-1:0]        HWDATA,
    input  logic                     HREADY,
    input  logic                     HRESP,
    input  logic [DATA_W-1:0]        HRDATA
);

    localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int MAXSZ = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_LERR} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       last_q, last_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NREQ-1:0]     req_ready_q, req_ready_d;
    logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                busy_q, busy_d;
    logic                hsel_q, hsel_d;
    logic [ADDR_W-1:0]   haddr_q, haddr_d;
    logic [1:0]          htrans_q, htrans_d;
    logic                hwrite_q, hwrite_d;
    logic [2:0]          hsize_q, hsize_d;
    logic [DATA_W-1:0]   hwdata_q, hwdata_d;

    logic                any_req;
    logic [IW-1:0]       pick;
    logic [ADDR_W-1:0]   g_addr;
    logic [2:0]          g_size;
    logic [DATA_W-1:0]   g_wdata;
    logic                g_write;
    logic                illegal;

    // First requester after the previous winner, wrapping around.
    always_comb begin
        any_req = 1'b0;
        pick    = last_q;
        for (int i = 1; i <= NREQ; i++) begin
            if (!any_req && req_valid[(int'(last_q) + i) % NREQ]) begin
                any_req = 1'b1;
                pick    = IW'((int'(last_q) + i) % NREQ);
            end
        end
    end

    assign g_addr  = req_addr[int'(pick)*ADDR_W +: ADDR_W];
    assign g_size  = req_size[int'(pick)*3 +: 3];
    assign g_wdata = req_wdata[int'(pick)*DATA_W +: DATA_W];
    assign g_write = req_write[pick];
    assign illegal = (int'(g_size) > MAXSZ) ||
                     ((g_addr & ((ADDR_W'(1) << g_size) - ADDR_W'(1))) != '0);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            last_q      <= IW'(NREQ - 1);
            wdata_q     <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            hsel_q      <= 1'b0;
            haddr_q     <= '0;
            htrans_q    <= 2'b00;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'b000;
            hwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
            hsel_q      <= hsel_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = illegal ? S_LERR : S_ADDR;
            S_ADDR:  if (HREADY) state_d = S_DATA;
            S_DATA:  if (HREADY) state_d = S_IDLE;
            S_LERR:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so every port comes from a flop;
    // last_q doubles as the index of the client currently being served.
    always_comb begin
        last_d      = last_q;
        wdata_d     = wdata_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        busy_d      = (state_d != S_IDLE);
        hsel_d      = hsel_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    req_ready_d[pick] = 1'b1;
                    last_d            = pick;
                    haddr_d           = g_addr;
                    hwrite_d          = g_write;
                    hsize_d           = g_size;
                    wdata_d           = g_wdata;
                    if (!illegal) begin
                        hsel_d   = 1'b1;
                        htrans_d = 2'b10;
                    end
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    hsel_d   = 1'b0;
                    htrans_d = 2'b00;
                    if (hwrite_q) hwdata_d = wdata_q;
                end
            end
            S_DATA: begin
                if (HREADY) begin
                    rsp_valid_d[last_q] = 1'b1;
                    rsp_err_d           = HRESP;
                    if (!hwrite_q) rsp_rdata_d = HRDATA;
                end
            end
            S_LERR: begin
                rsp_valid_d[last_q] = 1'b1;
                rsp_err_d           = 1'b1;
            end
            default: ;
        endcase
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;
    assign HSEL      = hsel_q;
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HWDATA    = hwdata_q;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Directed bench for ahb_req_arbiter: table of single transfers plus
// hand-written round-robin, wait-state, error and mid-transfer reset cases.
module tb_ahb_req_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic                 HCLK = 1'b0;
    logic                 HRESETn = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_write = '0;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ*3-1:0]    req_size = '0;
    logic [NREQ*DW-1:0]   req_wdata = '0;
    logic [NREQ-1:0]      rsp_valid;
    logic                 rsp_err;
    logic [DW-1:0]        rsp_rdata;
    logic                 busy;
    logic                 HSEL;
    logic [AW-1:0]        HADDR;
    logic [1:0]           HTRANS;
    logic                 HWRITE;
    logic [2:0]           HSIZE;
    logic [2:0]           HBURST;
    logic [3:0]           HPROT;
    logic [DW-1:0]        HWDATA;
    logic                 HREADY = 1'b1;
    logic                 HRESP = 1'b0;
    logic [DW-1:0]        HRDATA;

    always #5 HCLK = ~HCLK;

    ahb_req_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    // Word-addressed slave memory, 16 words.
    logic [31:0] mem [0:15];
    logic        dph_q, dwr_q;
    logic [3:0]  dad_q;
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dph_q <= 1'b0; dwr_q <= 1'b0; dad_q <= 4'd0;
        end else if (HREADY) begin
            if (dph_q && dwr_q) mem[dad_q] <= HWDATA;
            dph_q <= HSEL && (HTRANS == 2'b10);
            dwr_q <= HWRITE;
            dad_q <= HADDR[5:2];
        end
    end
    assign HRDATA = mem[dad_q];

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_rd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        ill;
        logic [31:0] rdata;
    } vec_t;

    task automatic set_req(input int c, input logic wr, input logic [31:0] addr,
                           input logic [2:0] size, input logic [31:0] wdata);
        req_write[c]          = wr;
        req_addr[c*AW +: AW]  = addr;
        req_size[c*3 +: 3]    = size;
        req_wdata[c*DW +: DW] = wdata;
    endtask

    // Client c issues one request, starting from an idle arbiter.
    task automatic run_vec(input int c, input vec_t v);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << c;
        set_req(c, v.wr, v.addr, v.size, v.wdata);
        req_valid[c] = 1'b1;
        tick();
        req_valid[c] = 1'b0;
        chk("grant_ready", req_ready, oh);
        chk("grant_busy", busy, 1);
        if (v.ill) begin
            chk("ill_no_nonseq", HTRANS, 2'b00);
            chk("ill_no_hsel", HSEL, 0);
            tick();
            chk("ill_rsp_valid", rsp_valid, oh);
            chk("ill_rsp_err", rsp_err, 1);
            chk("ill_rdata_hold", rsp_rdata, exp_rd);
        end else begin
            chk("addr_htrans", HTRANS, 2'b10);
            chk("addr_hsel", HSEL, 1);
            chk("addr_haddr", HADDR, v.addr);
            chk("addr_hwrite", HWRITE, v.wr);
            chk("addr_hsize", HSIZE, v.size);
            chk("addr_hprot", HPROT, 4'b0011);
            chk("addr_hburst", HBURST, 3'b000);
            tick();
            chk("data_htrans", HTRANS, 2'b00);
            chk("data_hsel", HSEL, 0);
            chk("data_no_rsp", rsp_valid, 0);
            if (v.wr) chk("data_hwdata", HWDATA, v.wdata);
            tick();
            if (!v.wr) exp_rd = v.rdata;
            chk("rsp_valid", rsp_valid, oh);
            chk("rsp_err", rsp_err, 0);
            chk("rsp_rdata", rsp_rdata, exp_rd);
            chk("rsp_idle", busy, 0);
        end
    endtask

    vec_t tbl [9];

    initial begin
        int ng, last_t, t;
        logic [31:0] haddr_snap;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        tbl[0] = '{wr:1'b1, addr:32'h10, size:3'd2, wdata:32'hDEADBEEF, ill:1'b0, rdata:32'h0};
        tbl[1] = '{wr:1'b0, addr:32'h10, size:3'd2, wdata:32'h0,        ill:1'b0, rdata:32'hDEADBEEF};
        tbl[2] = '{wr:1'b1, addr:32'h14, size:3'd2, wdata:32'h12345678, ill:1'b0, rdata:32'h0};
        tbl[3] = '{wr:1'b0, addr:32'h14, size:3'd2, wdata:32'h0,        ill:1'b0, rdata:32'h12345678};
        tbl[4] = '{wr:1'b0, addr:32'h3,  size:3'd2, wdata:32'h0,        ill:1'b1, rdata:32'h0};
        tbl[5] = '{wr:1'b1, addr:32'h8,  size:3'd3, wdata:32'h55,       ill:1'b1, rdata:32'h0};
        tbl[6] = '{wr:1'b1, addr:32'h6,  size:3'd1, wdata:32'hA5A5,     ill:1'b0, rdata:32'h0};
        tbl[7] = '{wr:1'b0, addr:32'h10, size:3'd2, wdata:32'h0,        ill:1'b0, rdata:32'hDEADBEEF};
        tbl[8] = '{wr:1'b0, addr:32'h1,  size:3'd0, wdata:32'h0,        ill:1'b0, rdata:32'h0};

        // Reset values.
        repeat (3) tick();
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_hsel", HSEL, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_busy", busy, 0);
        HRESETn = 1'b1;
        tick();

        // Both clients requesting continuously: alternate grants every 3 cycles.
        set_req(0, 1'b1, 32'h20, 3'd2, 32'h1000);
        set_req(1, 1'b1, 32'h24, 3'd2, 32'h1001);
        req_valid = 2'b11;
        ng = 0; last_t = 0; t = 0;
        while (ng < 6 && t < 40) begin
            tick();
            t++;
            if (req_ready != '0) begin
                chk("rr_onehot", $onehot(req_ready), 1);
                chk("rr_order", req_ready, (ng % 2 == 0) ? 2'b01 : 2'b10);
                if (ng > 0) chk("rr_spacing", t - last_t, 3);
                last_t = t;
                ng++;
                if (ng == 6) req_valid = '0;
            end
        end
        chk("rr_count", ng, 6);
        tick(); tick();
        chk("rr_last_rsp", rsp_valid, 2'b10);
        tick();
        chk("rr_mem0", mem[8], 32'h1000);
        chk("rr_mem1", mem[9], 32'h1001);

        // Single transfers from the table.
        for (int i = 0; i < 9; i++) run_vec(0, tbl[i]);
        tick();

        // Two wait states in the data phase.
        set_req(0, 1'b0, 32'h14, 3'd2, 32'h0);
        req_valid[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        haddr_snap = HADDR;
        chk("ws_nonseq", HTRANS, 2'b10);
        tick();
        HREADY = 1'b0;
        tick();
        chk("ws_haddr_stable", HADDR, haddr_snap);
        chk("ws_no_rsp1", rsp_valid, 0);
        chk("ws_htrans_idle", HTRANS, 2'b00);
        tick();
        HREADY = 1'b1;
        chk("ws_no_rsp2", rsp_valid, 0);
        chk("ws_busy", busy, 1);
        tick();
        exp_rd = 32'h12345678;
        chk("ws_rsp_valid", rsp_valid, 2'b01);
        chk("ws_rdata", rsp_rdata, exp_rd);
        chk("ws_err", rsp_err, 0);
        tick();

        // Two-cycle error response.
        set_req(1, 1'b1, 32'h30, 3'd2, 32'hBAD0BAD0);
        req_valid[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        chk("err_grant", req_ready, 2'b10);
        tick();
        HRESP = 1'b1; HREADY = 1'b0;
        tick();
        chk("err_htrans1", HTRANS, 2'b00);
        chk("err_no_rsp", rsp_valid, 0);
        HREADY = 1'b1;
        tick();
        HRESP = 1'b0;
        chk("err_htrans2", HTRANS, 2'b00);
        chk("err_rsp_valid", rsp_valid, 2'b10);
        chk("err_rsp_err", rsp_err, 1);
        chk("err_rdata_hold", rsp_rdata, exp_rd);
        tick();

        // Reset while in the address phase; client 0 last granted beforehand.
        set_req(0, 1'b0, 32'h10, 3'd2, 32'h0);
        req_valid[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        chk("mid_nonseq", HTRANS, 2'b10);
        HRESETn = 1'b0;
        #1;
        chk("mid_htrans", HTRANS, 2'b00);
        chk("mid_hsel", HSEL, 0);
        chk("mid_busy", busy, 0);
        chk("mid_rdata", rsp_rdata, 0);
        exp_rd = '0;
        tick();
        HRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_rsp", rsp_valid, 0);
        end
        set_req(1, 1'b0, 32'h14, 3'd2, 32'h0);
        req_valid = 2'b11;
        tick();
        req_valid = '0;
        chk("post_rst_grant", req_ready, 2'b01);
        tick(); tick();
        exp_rd = 32'hDEADBEEF;
        chk("post_rst_rsp", rsp_valid, 2'b01);
        chk("post_rst_rdata", rsp_rdata, exp_rd);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
